// File: rtl/pipe_pkg.sv
// Shared types and stage indices for the pipeline stage controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FREEZE = 2'd2,
        FLUSH  = 2'd3
    } pipe_state_t;

    localparam int ST_ID    = 0;
    localparam int ST_EX    = 1;
    localparam int ST_MEM   = 2;
    localparam int ST_WB    = 3;
    localparam int N_STAGES = 4;

endpackage

// File: rtl/stage_valid_reg.sv
// One pipeline-stage valid flop: clear wins over write-enable, async active-high reset.
module stage_valid_reg (
    input  logic clk,
    input  logic rst,
    input  logic i_we,
    input  logic i_clr,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    // NOTE: sequential state uses non-blocking assignments only, so all flops sample together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_q <= 1'b0;
        else if (i_clr)
            r_q <= 1'b0;
        else if (i_we)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Hazard-unit consumer: stall/flush/freeze -> pipeline register enables, clears and stage valids.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2,
    parameter int MAX_STALL   = 15,
    parameter int CNT_W       = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic hz_flush,
    input  logic hz_flush_l,
    input  logic hz_stall,
    input  logic mem_busy,
    input  logic if_valid,
    output logic pc_we,
    output logic ifid_we,
    output logic ifid_clr,
    output logic idex_we,
    output logic idex_clr,
    output logic exmem_we,
    output logic v_id,
    output logic v_ex,
    output logic v_mem,
    output logic v_wb,
    output logic stall_timeout
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cyc_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int SR_W = $clog2(MAX_STALL + 1);

    pipe_state_t     r_state;
    pipe_state_t     w_next_state;
    logic            w_flush_evt;
    logic            w_stalling;
    logic [SR_W-1:0] r_stall_run;

    logic [N_STAGES-1:0] w_v_we;
    logic [N_STAGES-1:0] w_v_clr;
    logic [N_STAGES-1:0] w_v_d;
    logic [N_STAGES-1:0] w_valid;

    // A stage that is cleared also has its enable dropped, matching the reset pattern.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_next_state = RUN;
        w_flush_evt  = 1'b0;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_clr     = 1'b0;
        idex_we      = 1'b1;
        idex_clr     = 1'b0;
        exmem_we     = 1'b1;
        if (rst) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            ifid_clr = 1'b1;
            idex_we  = 1'b0;
            idex_clr = 1'b1;
            exmem_we = 1'b0;
        end else if (mem_busy) begin
            w_next_state = FREEZE;
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
        end else if (hz_flush) begin
            w_next_state = FLUSH;
            w_flush_evt  = 1'b1;
            ifid_we      = 1'b0;
            ifid_clr     = 1'b1;
            if (FLUSH_DEPTH == 2) begin
                idex_we  = 1'b0;
                idex_clr = 1'b1;
            end
        end else if (hz_flush_l) begin
            w_next_state = FLUSH;
            w_flush_evt  = 1'b1;
            ifid_we      = 1'b0;
            ifid_clr     = 1'b1;
        end else if (hz_stall) begin
            w_next_state = STALL;
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            idex_clr     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= RUN;
        else
            r_state <= w_next_state;
    end

    assign w_stalling = (w_next_state == STALL) || (w_next_state == FREEZE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_run <= '0;
        else if (!w_stalling)
            r_stall_run <= '0;
        else if (r_stall_run != SR_W'(MAX_STALL))
            r_stall_run <= r_stall_run + SR_W'(1);
    end

    assign stall_timeout = (r_stall_run == SR_W'(MAX_STALL)) &&
                           ((r_state == STALL) || (r_state == FREEZE));

    // MEM/WB has no hazard-controlled register of its own; it advances with EX/MEM.
    assign w_v_we  = {exmem_we, exmem_we, idex_we, ifid_we};
    assign w_v_clr = {1'b0, 1'b0, idex_clr, ifid_clr};
    assign w_v_d   = {w_valid[ST_MEM], w_valid[ST_EX], w_valid[ST_ID], if_valid};

    for (genvar g = 0; g < N_STAGES; g++) begin : g_valid
        stage_valid_reg u_valid (
            .clk   (clk),
            .rst   (rst),
            .i_we  (w_v_we[g]),
            .i_clr (w_v_clr[g]),
            .i_d   (w_v_d[g]),
            .o_q   (w_valid[g])
        );
    end

    assign v_id  = w_valid[ST_ID];
    assign v_ex  = w_valid[ST_EX];
    assign v_mem = w_valid[ST_MEM];
    assign v_wb  = w_valid[ST_WB];

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cyc_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cyc_cnt <= '0;
            r_flush_cnt     <= '0;
        end else begin
            if (w_stalling)
                r_stall_cyc_cnt <= r_stall_cyc_cnt + CNT_W'(1);
            if (w_flush_evt)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cyc_cnt = r_stall_cyc_cnt;
    assign flush_cnt     = r_flush_cnt;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    logic             w_unused_flush;
    assign w_unused_cnt   = '0;
    assign w_unused_flush = w_flush_evt;
`endif

endmodule
